if_id_ctrl: RTL
===============

Name: if_id_ctrl

Overview:
- Sits directly downstream of the fetch stage in the 3-stage RV32I pipeline.
- Generates the fetch PC select and external PC (boot vector or branch/jump target) for the fetch stage.
- Owns the IF→EX pipeline register: captures the instruction/PC pair from fetch and kills wrong-path fetches on redirect.
- Holds the pipeline under stall and counts instructions issued to EX.

Parameters:
RESET_PC, 32'h0000_2000, boot vector driven to fetch's external-PC input after reset
NOP_INSTR, 32'h0000_0013, bubble inserted on kill/boot (addi x0,x0,0)
CNT_W, 32, width of issued-instruction counter

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
if_instr  in  32  instruction from fetch IMEM port B, aligned with if_pc
if_pc  in  32  fetch PC register output
stall  in  1  hold request from hazard logic
redirect  in  1  branch taken / jump resolved in EX this cycle
redirect_pc  in  32  target for redirect
pc_sel  out  2  fetch mux select: 0=pc_ext, 1=hold (PC reg), 2=PC+4
pc_ext  out  32  external PC into fetch mux input 0
ex_instr  out  32  registered instruction to EX
ex_pc  out  32  registered PC to EX
ex_valid  out  1  ex_instr is a real (non-bubble) instruction
issued_cnt  out  CNT_W  count of valid instructions latched into EX

Behaviour:
- Fetch timing: the fetch PC reg and IMEM port B both update on the same edge, so if_instr always belongs to if_pc; no extra alignment needed.
- FSM states: BOOT, RUN.
- Reset (rst==0 at an edge):
  - state<=BOOT, ex_instr<=NOP_INSTR, ex_pc<=0, ex_valid<=0, issued_cnt<=0.
  - Reset mid-operation discards everything in flight.
- BOOT (combinational outputs):
  - pc_sel=0, pc_ext=RESET_PC.
  - EX register loads the bubble (NOP_INSTR, ex_valid=0).
  - Next state RUN unconditionally; stall and redirect are ignored in BOOT.
- RUN, priority redirect > stall > normal:
  - redirect=1: pc_sel=0, pc_ext=redirect_pc. The fetch currently at if_pc is wrong-path, so EX loads the bubble (ex_valid<=0, ex_pc<=if_pc). Redirect wins even if stall=1.
  - stall=1 and redirect=0: pc_sel=1. ex_instr, ex_pc, ex_valid and issued_cnt all hold.
  - otherwise: pc_sel=2; ex_instr<=if_instr, ex_pc<=if_pc, ex_valid<=1, issued_cnt+=1.
- pc_ext equals RESET_PC whenever pc_sel!=0 in RUN (keeps the mux input stable, no X).
- Redirect on consecutive cycles: each one kills the current fetch. The first instruction at a target reaches EX one edge after the last redirect.
- issued_cnt wraps modulo 2^CNT_W with no saturation and no flag.
- Latency: instruction at if_pc appears on ex_instr one clock later (no stall).
- Redirect penalty: exactly one bubble.
- pc_sel encoding is combinational from state/stall/redirect. All ex_* outputs are registered.
- stall/redirect X while rst==0 have no effect.

Decomposition:
- Shared package: pc_sel encodings (PCSEL_EXT=2'd0, PCSEL_HOLD=2'd1, PCSEL_INC=2'd2), NOP_INSTR constant, FSM state encoding.
- These encodings are shared with the fetch stage mux and the hazard unit.
- One natural sub-module: if_id_pipe_reg, the EX-side register holding instr/pc/valid with load, hold and bubble controls.
- The FSM and counter stay in the top.

Test Plan:
- Reset then release, IMEM[0x2000]=0x00500093: cycle 0 pc_sel=0/pc_ext=0x2000/ex_valid=0; cycle 1 pc_sel=2; cycle 2 ex_instr=0x00500093, ex_pc=0x2000, ex_valid=1, issued_cnt=1.
- Straight-line 4 instructions: ex_pc 0x2000,0x2004,0x2008,0x200C on consecutive cycles, issued_cnt=4.
- Stall 3 cycles at if_pc=0x2008: pc_sel=1 three cycles; ex_pc/ex_instr frozen, issued_cnt unchanged; 0x2008 reaches EX on the first cycle after stall drops.
- Redirect to 0x2100 while if_pc=0x200C, stall=1 concurrently: pc_sel=0, pc_ext=0x2100; next cycle ex_valid=0 (0x200C killed); following cycle ex_pc=0x2100, ex_valid=1.
- Back-to-back redirects to 0x2100 then 0x2200: two bubbles; 0x2100 never reaches EX with ex_valid=1.
- rst pulled low mid-stream with issued_cnt=7: next cycle issued_cnt=0, ex_valid=0, state BOOT, pc_ext=RESET_PC.
- CNT_W=4 build, 17 valid issues: issued_cnt wraps to 1.

Source files
------------

// File: rtl/if_id_ctrl_pkg.sv
// Shared definitions for the IF->EX control block, the fetch-stage PC mux and
// the hazard unit: PC-select encodings, the bubble instruction, FSM states and
// the EX-side pipeline register payload.
package if_id_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  // Fetch PC mux select encodings
  localparam logic [1:0] PCSEL_EXT  = 2'd0;
  localparam logic [1:0] PCSEL_HOLD = 2'd1;
  localparam logic [1:0] PCSEL_INC  = 2'd2;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } ex_payload_t;

endpackage

// File: rtl/if_id_ctrl_pipe_reg.sv
// EX-side pipeline register holding instr/pc/valid.
// Ports: clk, rst (sync, active-low), bubble_i (load NOP, valid=0, keep pc_i),
//        load_i (capture instr_i/pc_i as valid), instr_i, pc_i, ex_o (payload).
// With neither bubble_i nor load_i asserted the register holds.
module if_id_pipe_reg
  import if_id_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = if_id_ctrl_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            bubble_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output ex_payload_t     ex_o
);

  ex_payload_t ex_q;

  // Bubble has priority over load
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
    end else if (bubble_i) begin
      ex_q <= '{instr: NOP_INSTR, pc: pc_i, valid: 1'b0};
    end else if (load_i) begin
      ex_q <= '{instr: instr_i, pc: pc_i, valid: 1'b1};
    end
  end

  assign ex_o = ex_q;

endmodule

// File: rtl/if_id_ctrl.sv
// IF->EX control for the 3-stage RV32I pipeline.
// Drives the fetch PC select / external PC, owns the IF->EX register, kills
// wrong-path fetches on redirect, holds on stall and counts issued instructions.
// Ports: clk, rst (sync, active-low); if_instr/if_pc from fetch; stall,
//        redirect, redirect_pc from hazard/EX; pc_sel, pc_ext to fetch mux
//        (combinational); ex_instr, ex_pc, ex_valid, issued_cnt (registered).
module if_id_ctrl
  import if_id_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_2000,
  parameter logic [XLEN-1:0] NOP_INSTR = if_id_ctrl_pkg::NOP_INSTR,
  parameter int unsigned     CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_instr,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic [1:0]       pc_sel,
  output logic [XLEN-1:0]  pc_ext,
  output logic [XLEN-1:0]  ex_instr,
  output logic [XLEN-1:0]  ex_pc,
  output logic             ex_valid,
  output logic [CNT_W-1:0] issued_cnt
);

  state_e           state_q, state_d;
  logic             load, bubble, cnt_inc;
  logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
  ex_payload_t      ex_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and fetch/EX controls; redirect > stall > normal in RUN
  always_comb begin
    state_d = state_q;
    pc_sel  = PCSEL_INC;
    pc_ext  = RESET_PC;
    load    = 1'b0;
    bubble  = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        pc_sel  = PCSEL_EXT;
        bubble  = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          // Current fetch is wrong-path: kill it
          pc_sel = PCSEL_EXT;
          pc_ext = redirect_pc;
          bubble = 1'b1;
        end else if (stall) begin
          pc_sel = PCSEL_HOLD;
        end else begin
          pc_sel  = PCSEL_INC;
          load    = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Issued-instruction counter, wraps freely
  assign issued_cnt_d = cnt_inc ? issued_cnt_q + CNT_W'(1) : issued_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      issued_cnt_q <= '0;
    end else begin
      issued_cnt_q <= issued_cnt_d;
    end
  end

  if_id_pipe_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_pipe_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .bubble_i (bubble),
    .instr_i  (if_instr),
    .pc_i     (if_pc),
    .ex_o     (ex_q)
  );

  assign ex_instr   = ex_q.instr;
  assign ex_pc      = ex_q.pc;
  assign ex_valid   = ex_q.valid;
  assign issued_cnt = issued_cnt_q;

endmodule
